pad_ctrl_bidir: RTL and testbench

//  Core-side controller for a bank of NUM_PADS bidirectional FPGA pads. Drives each pad's

---
 rtl/pad_ctrl_bidir.sv | 156 +++++++++++++++
 tb/tb_pad_ctrl_bidir.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_ctrl_bidir.sv
// pad_ctrl_bidir: core-side controller for a bank of bidirectional pads.
// Each pad gets a direction FSM (IN/SETUP/OUT/TURN) for safe turnaround,
// open-drain emulation, a 2-FF input synchronizer, a programmable glitch
// filter and rise/fall event pulses. Pads are fully independent.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   cfg_dir_i           1 = output, 0 = input (per pad)
//   cfg_out_i           output data value (per pad)
//   cfg_od_i            1 = open-drain, drive low only (per pad)
//   cfg_filt_en_i       1 = glitch filter enabled (per pad)
//   cfg_filt_cycles_i   stable cycles required by the filter (shared, 0 acts as 1)
//   pad_in_i            raw asynchronous pad input
//   pad_oen_o           active-low output enable (1 = high-Z)
//   pad_out_o           output data to the pad
//   in_sync_o           synchronized pad input
//   in_filt_o           filtered pad input
//   rise_o / fall_o     one-cycle pulses on in_filt_o edges
module pad_ctrl_bidir #(
  parameter int unsigned NUM_PADS    = 8,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_PADS-1:0] cfg_dir_i,
  input  logic [NUM_PADS-1:0] cfg_out_i,
  input  logic [NUM_PADS-1:0] cfg_od_i,
  input  logic [NUM_PADS-1:0] cfg_filt_en_i,
  input  logic [CNT_W-1:0]    cfg_filt_cycles_i,
  input  logic [NUM_PADS-1:0] pad_in_i,
  output logic [NUM_PADS-1:0] pad_oen_o,
  output logic [NUM_PADS-1:0] pad_out_o,
  output logic [NUM_PADS-1:0] in_sync_o,
  output logic [NUM_PADS-1:0] in_filt_o,
  output logic [NUM_PADS-1:0] rise_o,
  output logic [NUM_PADS-1:0] fall_o
);

  localparam int unsigned TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IN    = 2'd0,
    ST_SETUP = 2'd1,
    ST_OUT   = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  // Shared filter threshold; a programmed 0 behaves like 1.
  logic [CNT_W-1:0] filt_thr;
  assign filt_thr = (cfg_filt_cycles_i == '0) ? CNT_W'(1) : cfg_filt_cycles_i;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    state_t            state_q;
    state_t            state_d;
    logic              oen_q;
    logic              out_q;
    logic              sync1_q;
    logic              sync_q;
    logic              filt_q;
    logic              filt_prev_q;
    logic              rise_q;
    logic              fall_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [TURN_W-1:0] turn_q;
    logic              drive_val;
    logic              drive_oen;
    logic              edge_ok;

    // Open-drain drives a constant 0 and expresses data through the enable.
    assign drive_val = cfg_od_i[g] ? 1'b0 : cfg_out_i[g];
    assign drive_oen = cfg_od_i[g] ? cfg_out_i[g] : 1'b0;
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign edge_ok   = (state_q == ST_IN) || (state_q == ST_OUT);

    // Direction next-state.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        ST_IN:    if (cfg_dir_i[g]) state_d = ST_SETUP;
        ST_SETUP: state_d = cfg_dir_i[g] ? ST_OUT : ST_IN;
        ST_OUT:   if (!cfg_dir_i[g]) state_d = ST_TURN;
        ST_TURN: begin
          if (cfg_dir_i[g])        state_d = ST_SETUP;
          else if (turn_q == '0)   state_d = ST_IN;
        end
        default:  state_d = ST_IN;
      endcase
    end

    // State, registered pad drive, synchronizer, filter and edge pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q     <= ST_IN;
        oen_q       <= 1'b1;
        out_q       <= 1'b0;
        sync1_q     <= 1'b0;
        sync_q      <= 1'b0;
        filt_q      <= 1'b0;
        filt_prev_q <= 1'b0;
        rise_q      <= 1'b0;
        fall_q      <= 1'b0;
        cnt_q       <= '0;
        turn_q      <= '0;
      end else begin
        state_q <= state_d;
        sync1_q <= pad_in_i[g];
        sync_q  <= sync1_q;

        // Drive values track the state being entered so they change with it.
        unique case (state_d)
          ST_SETUP: begin oen_q <= 1'b1;      out_q <= drive_val; end
          ST_OUT:   begin oen_q <= drive_oen; out_q <= drive_val; end
          default:  begin oen_q <= 1'b1;      out_q <= 1'b0;      end
        endcase

        if (state_d == ST_TURN && state_q != ST_TURN) begin
          turn_q <= TURN_W'(TURN_CYCLES - 1);
        end else if (state_q == ST_TURN && turn_q != '0) begin
          turn_q <= turn_q - TURN_W'(1);
        end

        filt_prev_q <= filt_q;
        if (state_q == ST_TURN) begin
          // Filter frozen while turning; on exit resync without an edge pulse.
          cnt_q <= '0;
          if (state_d != ST_TURN) begin
            filt_q      <= sync_q;
            filt_prev_q <= sync_q;
          end
        end else if (!cfg_filt_en_i[g]) begin
          filt_q <= sync_q;
          cnt_q  <= '0;
        end else if (sync_q == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_inc >= filt_thr) begin
          filt_q <= sync_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_inc;
        end

        rise_q <= edge_ok &  filt_q & ~filt_prev_q;
        fall_q <= edge_ok & ~filt_q &  filt_prev_q;
      end
    end

    assign pad_oen_o[g] = oen_q;
    assign pad_out_o[g] = out_q;
    assign in_sync_o[g] = sync_q;
    assign in_filt_o[g] = filt_q;
    assign rise_o[g]    = rise_q;
    assign fall_o[g]    = fall_q;
  end

endmodule

// File: tb/tb_pad_ctrl_bidir.sv
// Testbench for pad_ctrl_bidir: directed stimulus pushes expected values
// (cycle, signal, mask, value) into a scoreboard queue; a negedge monitor
// pops and compares entries whose cycle has arrived.
module tb_pad_ctrl_bidir;

  localparam int unsigned NP = 8;
  localparam int unsigned CW = 8;

  localparam int S_OEN  = 0;
  localparam int S_OUT  = 1;
  localparam int S_SYNC = 2;
  localparam int S_FILT = 3;
  localparam int S_RISE = 4;
  localparam int S_FALL = 5;

  logic          clk;
  logic          rst_n;
  logic [NP-1:0] cfg_dir;
  logic [NP-1:0] cfg_out;
  logic [NP-1:0] cfg_od;
  logic [NP-1:0] cfg_filt_en;
  logic [CW-1:0] cfg_filt_cycles;
  logic [NP-1:0] pad_in;
  logic [NP-1:0] pad_oen;
  logic [NP-1:0] pad_out;
  logic [NP-1:0] in_sync;
  logic [NP-1:0] in_filt;
  logic [NP-1:0] rise;
  logic [NP-1:0] fall;

  pad_ctrl_bidir #(.NUM_PADS(NP), .CNT_W(CW), .TURN_CYCLES(2)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .cfg_dir_i         (cfg_dir),
    .cfg_out_i         (cfg_out),
    .cfg_od_i          (cfg_od),
    .cfg_filt_en_i     (cfg_filt_en),
    .cfg_filt_cycles_i (cfg_filt_cycles),
    .pad_in_i          (pad_in),
    .pad_oen_o         (pad_oen),
    .pad_out_o         (pad_out),
    .in_sync_o         (in_sync),
    .in_filt_o         (in_filt),
    .rise_o            (rise),
    .fall_o            (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            at;
    int            sig;
    logic [NP-1:0] mask;
    logic [NP-1:0] val;
    int            id;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;

  function automatic logic [NP-1:0] sel(input int sig);
    case (sig)
      S_OEN:   return pad_oen;
      S_OUT:   return pad_out;
      S_SYNC:  return in_sync;
      S_FILT:  return in_filt;
      S_RISE:  return rise;
      default: return fall;
    endcase
  endfunction

  function automatic string sname(input int sig);
    case (sig)
      S_OEN:   return "pad_oen";
      S_OUT:   return "pad_out";
      S_SYNC:  return "in_sync";
      S_FILT:  return "in_filt";
      S_RISE:  return "rise";
      default: return "fall";
    endcase
  endfunction

  task automatic exp_push(input int d, input int sig, input logic [NP-1:0] m,
                          input logic [NP-1:0] v);
    exp_t e;
    e.at = cyc + d; e.sig = sig; e.mask = m; e.val = v & m; e.id = next_id;
    next_id++;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every scoreboard entry due in the current cycle.
  always @(negedge clk) begin : mon
    logic [NP-1:0] got;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].at == cyc) begin
        got = sel(sbq[i].sig) & sbq[i].mask;
        checks++;
        if (got !== sbq[i].val) begin
          errors++;
          $display("FAIL chk%0d %s @cyc %0d: got %b expected %b (mask %b)",
                   sbq[i].id, sname(sbq[i].sig), cyc, got, sbq[i].val, sbq[i].mask);
        end
        sbq.delete(i);
      end else if (sbq[i].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL chk%0d %s: missed cycle %0d, now %0d", sbq[i].id,
                 sname(sbq[i].sig), sbq[i].at, cyc);
        sbq.delete(i);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cfg_dir = '0; cfg_out = '0; cfg_od = '0; cfg_filt_en = '0;
    cfg_filt_cycles = '0; pad_in = '0;

    // Reset state.
    tick();
    exp_push(0, S_OEN,  8'hFF, 8'hFF);
    exp_push(0, S_OUT,  8'hFF, 8'h00);
    exp_push(0, S_SYNC, 8'hFF, 8'h00);
    exp_push(0, S_FILT, 8'hFF, 8'h00);
    exp_push(0, S_RISE, 8'hFF, 8'h00);
    exp_push(0, S_FALL, 8'hFF, 8'h00);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Pad 3 input -> output: SETUP loads data with oen high, then drives.
    cfg_out[3] = 1'b1; cfg_dir[3] = 1'b1;
    exp_push(1, S_OEN, 8'h08, 8'h08);
    exp_push(1, S_OUT, 8'h08, 8'h08);
    exp_push(2, S_OEN, 8'h08, 8'h00);
    exp_push(2, S_OUT, 8'h08, 8'h08);
    repeat (3) tick();

    // Pad 3 output -> input while the pad input rises: no edge, filt resyncs at exit.
    cfg_dir[3] = 1'b0; pad_in[3] = 1'b1;
    exp_push(1, S_OEN,  8'h08, 8'h08);
    exp_push(2, S_SYNC, 8'h08, 8'h08);
    exp_push(2, S_FILT, 8'h08, 8'h00);
    exp_push(3, S_FILT, 8'h08, 8'h08);
    for (int d = 1; d <= 5; d++) begin
      exp_push(d, S_RISE, 8'h08, 8'h00);
      exp_push(d, S_FALL, 8'h08, 8'h00);
    end
    repeat (6) tick();

    // Pad 3 falls in IN with filter off: one fall pulse.
    pad_in[3] = 1'b0;
    exp_push(3, S_FILT, 8'h08, 8'h00);
    exp_push(4, S_FALL, 8'h08, 8'h08);
    exp_push(4, S_RISE, 8'h08, 8'h00);
    exp_push(5, S_FALL, 8'h08, 8'h00);
    repeat (6) tick();

    // Pad 5 filter of 4: a 3-cycle glitch is rejected.
    cfg_filt_en[5] = 1'b1; cfg_filt_cycles = 8'd4;
    tick();
    pad_in[5] = 1'b1;
    for (int d = 3; d <= 8; d++) begin
      exp_push(d, S_FILT, 8'h20, 8'h00);
      exp_push(d, S_RISE, 8'h20, 8'h00);
    end
    repeat (3) tick();
    pad_in[5] = 1'b0;
    repeat (6) tick();

    // Pad 5: a 4-cycle pulse passes and gives a single rise pulse.
    pad_in[5] = 1'b1;
    exp_push(5, S_FILT, 8'h20, 8'h00);
    exp_push(6, S_FILT, 8'h20, 8'h20);
    exp_push(6, S_RISE, 8'h20, 8'h00);
    exp_push(7, S_RISE, 8'h20, 8'h20);
    exp_push(8, S_RISE, 8'h20, 8'h00);
    repeat (4) tick();
    pad_in[5] = 1'b0;
    repeat (12) tick();

    // Pad 1 open-drain: data moves to the enable, pad_out stays 0.
    cfg_od[1] = 1'b1; cfg_out[1] = 1'b0; cfg_dir[1] = 1'b1;
    exp_push(1, S_OEN, 8'h02, 8'h02);
    exp_push(1, S_OUT, 8'h02, 8'h00);
    exp_push(2, S_OEN, 8'h02, 8'h00);
    exp_push(2, S_OUT, 8'h02, 8'h00);
    repeat (2) tick();
    cfg_out[1] = 1'b1;
    exp_push(1, S_OEN, 8'h02, 8'h02);
    exp_push(1, S_OUT, 8'h02, 8'h00);
    tick();
    cfg_out[1] = 1'b0;
    exp_push(1, S_OEN, 8'h02, 8'h00);
    exp_push(1, S_OUT, 8'h02, 8'h00);
    repeat (2) tick();

    // Threshold 0 acts as 1; all pads rise together.
    cfg_filt_en = 8'hFF; cfg_filt_cycles = 8'd0;
    tick();
    pad_in = 8'hFF;
    exp_push(2, S_SYNC, 8'hFF, 8'hFF);
    exp_push(2, S_FILT, 8'hFF, 8'h00);
    exp_push(3, S_FILT, 8'hFF, 8'hFF);
    exp_push(3, S_RISE, 8'hFF, 8'h00);
    exp_push(4, S_RISE, 8'hFF, 8'hFF);
    exp_push(5, S_RISE, 8'hFF, 8'h00);
    repeat (6) tick();

    // Pad 0 driving 1, then asynchronous reset mid-cycle.
    cfg_dir[0] = 1'b1; cfg_out[0] = 1'b1;
    exp_push(2, S_OEN, 8'h01, 8'h00);
    exp_push(2, S_OUT, 8'h01, 8'h01);
    repeat (3) tick();
    rst_n = 1'b0;
    exp_push(0, S_OEN,  8'hFF, 8'hFF);
    exp_push(0, S_OUT,  8'hFF, 8'h00);
    exp_push(0, S_SYNC, 8'hFF, 8'h00);
    exp_push(0, S_FILT, 8'hFF, 8'h00);
    exp_push(0, S_RISE, 8'hFF, 8'h00);
    tick();
    // Restart from IN: SETUP cycle first, so oen stays high one more cycle.
    rst_n = 1'b1;
    exp_push(1, S_OEN, 8'h01, 8'h01);
    exp_push(1, S_OUT, 8'h01, 8'h01);
    exp_push(2, S_OEN, 8'h01, 8'h00);
    repeat (4) tick();

    for (int k = 0; k < 50 && sbq.size() > 0; k++) tick();
    if (sbq.size() > 0) begin
      errors += sbq.size();
      $display("FAIL scoreboard_drain: %0d entries pending, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
